// File: rtl/uart_lcr_ctrl.sv
// uart_lcr_ctrl: line-control and divisor-latch register block for the UART.
// Host writes land in shadow registers. They are copied to the active
// registers only while the serial line is idle, so a frame already in flight
// never sees a format change part-way through.
//
// Ports
//   m_clk, reset        clock (rising edge); async active-low reset
//   address, wr_en,     host write port; DLL/DLM are only visible while the
//   data_in             shadow DLAB bit is set
//   rd_data             combinational read-back of the addressed shadow reg
//   line_idle           TX and RX are both between frames
//   WLS..BC             active LCR fields
//   DLAB                shadow DLAB bit (acts immediately)
//   divisor             active baud divisor, forced to 1 when zero
//   frame_bits          active frame length: start + data + parity + stop
//   stop_half           active stop length is 1.5 bits
//   cfg_pending         shadow is waiting for an idle line to commit
//   cfg_update          one-cycle pulse when the active registers load
module uart_lcr_ctrl #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] LCR_ADDR  = 'h0C,
  parameter logic [ADDR_W-1:0] DLL_ADDR  = 'h00,
  parameter logic [ADDR_W-1:0] DLM_ADDR  = 'h04,
  parameter logic [7:0]        LCR_RESET = 8'h03,
  parameter logic [15:0]       DIV_RESET = 16'd1
) (
  input  logic              m_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              wr_en,
  input  logic [7:0]        data_in,
  output logic [7:0]        rd_data,
  input  logic              line_idle,
  output logic [1:0]        WLS,
  output logic              STB,
  output logic              PEN,
  output logic              EPS,
  output logic              SP,
  output logic              BC,
  output logic              DLAB,
  output logic [15:0]       divisor,
  output logic [3:0]        frame_bits,
  output logic              stop_half,
  output logic              cfg_pending,
  output logic              cfg_update
);

  typedef struct packed {
    logic       dlab;
    logic       bc;
    logic       sp;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t      state, state_nx;
  lcr_t        sh_lcr, act_lcr;
  logic [15:0] sh_div, act_div;
  logic        hit_lcr, hit_dll, hit_dlm, wr_acc, commit;

  // DLAB comes from the shadow copy so a DLAB write retargets the very next
  // access, independent of the line state.
  assign hit_lcr = (address == LCR_ADDR);
  assign hit_dll = sh_lcr.dlab && (address == DLL_ADDR);
  assign hit_dlm = sh_lcr.dlab && (address == DLM_ADDR);
  assign wr_acc  = wr_en && (hit_lcr || hit_dll || hit_dlm);

  // Commit FSM. A write on an idle edge keeps us pending so the newest data
  // always commits as a whole on the next write-free idle edge.
  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    case (state)
      S_IDLE: if (wr_acc) state_nx = S_PEND;
      S_PEND: if (line_idle && !wr_acc) begin
        state_nx = S_IDLE;
        commit   = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cfg_update <= 1'b0;
    end else begin
      state      <= state_nx;
      cfg_update <= commit;
    end
  end

  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      sh_lcr <= LCR_RESET;
      sh_div <= DIV_RESET;
    end else if (wr_en) begin
      if (hit_lcr)      sh_lcr       <= data_in;
      else if (hit_dll) sh_div[7:0]  <= data_in;
      else if (hit_dlm) sh_div[15:8] <= data_in;
    end
  end

  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      act_lcr <= LCR_RESET;
      act_div <= DIV_RESET;
    end else if (commit) begin
      act_lcr <= sh_lcr;
      act_div <= sh_div;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (hit_lcr)      rd_data = sh_lcr;
    else if (hit_dll) rd_data = sh_div[7:0];
    else if (hit_dlm) rd_data = sh_div[15:8];
  end

  assign WLS         = act_lcr.wls;
  assign STB         = act_lcr.stb;
  assign PEN         = act_lcr.pen;
  assign EPS         = act_lcr.eps;
  assign SP          = act_lcr.sp;
  assign BC          = act_lcr.bc;
  assign DLAB        = sh_lcr.dlab;
  assign cfg_pending = (state == S_PEND);

  // A zero divisor would stall the baud generator; substitute 1 on the
  // active side only, read-back still shows what the host wrote.
  assign divisor = (act_div == 16'd0) ? 16'd1 : act_div;

  // start(1) + data(5+WLS) + parity + stop; 1.5 stop bits count as 2 here.
  assign frame_bits = 4'd6 + {2'b00, act_lcr.wls} + {3'b000, act_lcr.pen}
                    + (act_lcr.stb ? 4'd2 : 4'd1);
  assign stop_half  = act_lcr.stb && (act_lcr.wls == 2'b00);

endmodule
